multi_debouncer: RTL

Parametrised N-channel button debouncer for parking-system front-panel and sensor inputs (entry/exit buttons, barrier limit switches). Each channel synchronises a raw asynchronous input and filters bounce with a stability counter. It produces a clean level, one-cycle press/release pulses, and a one-shot long-press pulse. Outputs feed the parking controller FSM directly.

---
 rtl/debounce_pkg.sv | 18 +
 rtl/debounce_channel.sv | 111 +++++++++++
 rtl/multi_debouncer.sv | 60 ++++++
 3 files changed

// File: rtl/debounce_pkg.sv
// -----------------------------------------------------------------------------
// debounce_pkg
// Shared defaults and counter-sizing helper for the front-panel / sensor
// input debouncers (debounce_channel, multi_debouncer).
// -----------------------------------------------------------------------------
package debounce_pkg;

   localparam int DEFAULT_SYNC_STAGES   = 2;
   localparam int DEFAULT_STABLE_CYCLES = 16;
   localparam int DEFAULT_HOLD_CYCLES   = 1000;

   // Width of a counter that must be able to hold the value maxCount.
   // clog2(n)+1 bits always covers n itself, so no counter can wrap.
   function automatic int cntWidth(input int maxCount);
      return (maxCount < 1) ? 1 : $clog2(maxCount) + 1;
   endfunction

endpackage

// File: rtl/debounce_channel.sv
// -----------------------------------------------------------------------------
// debounce_channel
// One debounced input: synchroniser, stability filter, registered press /
// release pulses and a one-shot long-press pulse.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   inButton   raw asynchronous input (polarity set by ACTIVE_LOW)
//   outButton  debounced level, 1 = pressed
//   risePulse  one cycle, coincident with outButton going 0->1
//   fallPulse  one cycle, coincident with outButton going 1->0
//   holdPulse  one cycle, HOLD_CYCLES edges after the rise, once per press
// -----------------------------------------------------------------------------
module debounce_channel
   import debounce_pkg::*;
#(
   parameter int SYNC_STAGES   = DEFAULT_SYNC_STAGES,
   parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
   parameter int HOLD_CYCLES   = DEFAULT_HOLD_CYCLES,
   parameter int ACTIVE_LOW    = 0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic inButton,
   output logic outButton,
   output logic risePulse,
   output logic fallPulse,
   output logic holdPulse
);

   localparam logic IDLE_LEVEL = (ACTIVE_LOW != 0);
   localparam int   STAB_W     = cntWidth(STABLE_CYCLES);
   localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] syncReg;
   logic                   syncIn;
   logic [STAB_W-1:0]      stabCnt;

   // The raw level is synchronised first and inverted afterwards, so the
   // flops sit at the electrically idle level while in reset and no spurious
   // press is seen on release.
   // NOTE: every register here uses non-blocking assignments so all flops
   // sample the pre-edge values; blocking would collapse the sync chain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         syncReg <= {SYNC_STAGES{IDLE_LEVEL}};
      end else begin
         syncReg <= {syncReg[SYNC_STAGES-2:0], inButton};
      end
   end

   assign syncIn = syncReg[SYNC_STAGES-1] ^ IDLE_LEVEL;

   // Stability filter: the output only follows syncIn after STABLE_CYCLES
   // consecutive disagreeing edges; any agreement restarts the run.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stabCnt   <= '0;
         outButton <= 1'b0;
         risePulse <= 1'b0;
         fallPulse <= 1'b0;
      end else begin
         risePulse <= 1'b0;
         fallPulse <= 1'b0;
         if (syncIn == outButton) begin
            stabCnt <= '0;
         end else if (stabCnt == STAB_LAST) begin
            stabCnt   <= '0;
            outButton <= syncIn;
            risePulse <= syncIn;
            fallPulse <= ~syncIn;
         end else begin
            stabCnt <= stabCnt + 1'b1;
         end
      end
   end

   if (HOLD_CYCLES > 0) begin : gHold
      localparam int HOLD_W = cntWidth(HOLD_CYCLES);
      localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

      logic [HOLD_W-1:0] holdCnt;
      logic              fired;

      // The counter freezes once fired is set, so it saturates at
      // HOLD_CYCLES and the pulse cannot repeat within one press.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            holdCnt   <= '0;
            fired     <= 1'b0;
            holdPulse <= 1'b0;
         end else begin
            holdPulse <= 1'b0;
            if (!outButton) begin
               holdCnt <= '0;
               fired   <= 1'b0;
            end else if (!fired) begin
               holdCnt <= holdCnt + 1'b1;
               if (holdCnt == HOLD_LAST) begin
                  holdPulse <= 1'b1;
                  fired     <= 1'b1;
               end
            end
         end
      end
   end else begin : gNoHold
      assign holdPulse = 1'b0;
   end

endmodule

// File: rtl/multi_debouncer.sv
// -----------------------------------------------------------------------------
// multi_debouncer
// CHANNELS independent debouncers for parking front-panel buttons and
// barrier limit switches. Outputs are always active-high.
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   inButtons   [CHANNELS] raw asynchronous inputs
//   outButtons  [CHANNELS] debounced levels, 1 = pressed
//   risePulse   [CHANNELS] one-cycle press pulses
//   fallPulse   [CHANNELS] one-cycle release pulses
//   holdPulse   [CHANNELS] one-cycle long-press pulses (0 if HOLD_CYCLES=0)
// -----------------------------------------------------------------------------
module multi_debouncer
   import debounce_pkg::*;
#(
   parameter int CHANNELS      = 4,
   parameter int SYNC_STAGES   = DEFAULT_SYNC_STAGES,
   parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
   parameter int HOLD_CYCLES   = DEFAULT_HOLD_CYCLES,
   parameter int ACTIVE_LOW    = 0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [CHANNELS-1:0] inButtons,
   output logic [CHANNELS-1:0] outButtons,
   output logic [CHANNELS-1:0] risePulse,
   output logic [CHANNELS-1:0] fallPulse,
   output logic [CHANNELS-1:0] holdPulse
);

   if (CHANNELS < 1) begin : gBadChannels
      $error("multi_debouncer: CHANNELS must be >= 1");
   end
   if (SYNC_STAGES < 2) begin : gBadSync
      $error("multi_debouncer: SYNC_STAGES must be >= 2");
   end
   if (STABLE_CYCLES < 1) begin : gBadStable
      $error("multi_debouncer: STABLE_CYCLES must be >= 1");
   end

   for (genvar i = 0; i < CHANNELS; i++) begin : gChan
      debounce_channel #(
         .SYNC_STAGES  (SYNC_STAGES),
         .STABLE_CYCLES(STABLE_CYCLES),
         .HOLD_CYCLES  (HOLD_CYCLES),
         .ACTIVE_LOW   (ACTIVE_LOW)
      ) uChan (
         .clk      (clk),
         .rst_n    (rst_n),
         .inButton (inButtons[i]),
         .outButton(outButtons[i]),
         .risePulse(risePulse[i]),
         .fallPulse(fallPulse[i]),
         .holdPulse(holdPulse[i])
      );
   end

endmodule
